// File: rtl/perceptron_trainer.sv
// Sequential perceptron: accumulates one weighted feature per cycle, then
// optionally applies the saturating perceptron learning rule on a misprediction.
module perceptron_trainer #(
  parameter  int N_IN      = 7,
  parameter  int W_WIDTH   = 6,
  parameter  int ACC_WIDTH = 10,
  localparam int AW        = $clog2(N_IN + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_IN-1:0]             features,
  input  logic                        train,
  input  logic                        label,
  input  logic                        w_load,
  input  logic [AW-1:0]               w_addr,
  input  logic signed [W_WIDTH-1:0]   w_data,
  output logic                        out_valid,
  output logic                        out_class,
  output logic signed [ACC_WIDTH-1:0] out_score,
  output logic                        mispredict
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DECIDE,
    UPDATE
  } state_t;

  localparam logic [AW-1:0] BIAS_ADDR = AW'(N_IN);
  localparam logic [AW-1:0] LAST_IDX  = AW'(N_IN - 1);
  localparam logic signed [W_WIDTH-1:0] W_MAX = {1'b0, {(W_WIDTH-1){1'b1}}};
  localparam logic signed [W_WIDTH-1:0] W_MIN = {1'b1, {(W_WIDTH-1){1'b0}}};

  state_t                      state;
  logic signed [W_WIDTH-1:0]   weights [N_IN];
  logic signed [W_WIDTH-1:0]   bias;
  logic signed [ACC_WIDTH-1:0] acc;
  logic [AW-1:0]               idx;
  logic [N_IN-1:0]             features_q;
  logic                        train_q;
  logic                        label_q;
  logic signed [W_WIDTH-1:0]   cur_w;
  logic                        acc_class;

  function automatic logic signed [ACC_WIDTH-1:0] sext_w(input logic signed [W_WIDTH-1:0] v);
    return {{(ACC_WIDTH-W_WIDTH){v[W_WIDTH-1]}}, v};
  endfunction

  // One learning step of +1/-1, clamped to the representable weight range.
  function automatic logic signed [W_WIDTH-1:0] sat_step(input logic signed [W_WIDTH-1:0] v,
                                                         input logic up);
    logic signed [W_WIDTH-1:0] r;
    if (up) r = (v == W_MAX) ? v : v + W_WIDTH'(1);
    else    r = (v == W_MIN) ? v : v - W_WIDTH'(1);
    return r;
  endfunction

  assign in_ready  = (state == IDLE) && !w_load;
  assign acc_class = ~acc[ACC_WIDTH-1];

  always_comb begin
    cur_w = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (idx == AW'(i)) cur_w = weights[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bias       <= '0;
      acc        <= '0;
      idx        <= '0;
      features_q <= '0;
      train_q    <= 1'b0;
      label_q    <= 1'b0;
      out_valid  <= 1'b0;
      out_class  <= 1'b0;
      out_score  <= '0;
      mispredict <= 1'b0;
      for (int i = 0; i < N_IN; i++) weights[i] <= '0;
    end else if (ena) begin
      out_valid  <= 1'b0;
      mispredict <= 1'b0;
      case (state)
        IDLE: begin
          if (w_load) begin
            for (int i = 0; i < N_IN; i++) begin
              if (w_addr == AW'(i)) weights[i] <= w_data;
            end
            if (w_addr == BIAS_ADDR) bias <= w_data;
          end else if (in_valid) begin
            features_q <= features;
            train_q    <= train;
            label_q    <= label;
            acc        <= sext_w(bias);
            idx        <= '0;
            state      <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc + (features_q[idx] ? sext_w(cur_w) : '0);
          idx <= idx + AW'(1);
          if (idx == LAST_IDX) state <= DECIDE;
        end
        DECIDE: begin
          out_score <= acc;
          out_class <= acc_class;
          out_valid <= 1'b1;
          if (train_q && (acc_class != label_q)) begin
            mispredict <= 1'b1;
            state      <= UPDATE;
          end else begin
            state <= IDLE;
          end
        end
        UPDATE: begin
          for (int i = 0; i < N_IN; i++) begin
            if (features_q[i]) weights[i] <= sat_step(weights[i], label_q);
          end
          bias  <= sat_step(bias, label_q);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Randomised self-checking bench for perceptron_trainer against an
// arithmetic model of the weight set and the learning rule.
module tb_perceptron_trainer;

  localparam int N_IN      = 7;
  localparam int W_WIDTH   = 6;
  localparam int ACC_WIDTH = 10;
  localparam int AW        = 3;
  localparam int W_MAX     = 31;
  localparam int W_MIN     = -32;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        ena;
  logic                        in_valid;
  logic                        in_ready;
  logic [N_IN-1:0]             features;
  logic                        train;
  logic                        label;
  logic                        w_load;
  logic [AW-1:0]               w_addr;
  logic signed [W_WIDTH-1:0]   w_data;
  logic                        out_valid;
  logic                        out_class;
  logic signed [ACC_WIDTH-1:0] out_score;
  logic                        mispredict;

  int errors = 0;
  int checks = 0;
  int model_w [N_IN];
  int model_bias;

  perceptron_trainer #(.N_IN(N_IN), .W_WIDTH(W_WIDTH), .ACC_WIDTH(ACC_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .features(features), .train(train), .label(label), .w_load(w_load),
    .w_addr(w_addr), .w_data(w_data), .out_valid(out_valid), .out_class(out_class),
    .out_score(out_score), .mispredict(mispredict)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int model_score(input logic [N_IN-1:0] f);
    int s = model_bias;
    for (int i = 0; i < N_IN; i++) if (f[i]) s += model_w[i];
    return s;
  endfunction

  function automatic int clamp(input int v);
    return (v > W_MAX) ? W_MAX : (v < W_MIN) ? W_MIN : v;
  endfunction

  task automatic model_learn(input logic [N_IN-1:0] f, input logic lb);
    int d = lb ? 1 : -1;
    for (int i = 0; i < N_IN; i++) if (f[i]) model_w[i] = clamp(model_w[i] + d);
    model_bias = clamp(model_bias + d);
  endtask

  task automatic model_write(input int addr, input int value);
    if (addr < N_IN) model_w[addr] = value;
    else if (addr == N_IN) model_bias = value;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; w_load = 1'b0;
    features = '0; train = 1'b0; label = 1'b0; w_addr = '0; w_data = '0;
    for (int i = 0; i < N_IN; i++) model_w[i] = 0;
    model_bias = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_weight(input int addr, input int value);
    w_load = 1'b1;
    w_addr = addr[AW-1:0];
    w_data = value[W_WIDTH-1:0];
    @(negedge clk);
    w_load = 1'b0;
    model_write(addr, value);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkOutput("idle_timeout", 0, 1);
  endtask

  // One full transaction; ena is dropped for stall_len edges starting after stall_at edges.
  task automatic applyStimulus(input logic [N_IN-1:0] f, input logic tr, input logic lb,
                               input int stall_at, input int stall_len, input string tag);
    int  exp_score;
    int  exp_class;
    int  exp_mis;
    int  cnt = 0;
    bit  done = 0;
    wait_idle();
    exp_score = model_score(f);
    exp_class = (exp_score >= 0) ? 1 : 0;
    exp_mis   = (tr && (exp_class != int'(lb))) ? 1 : 0;
    features = f; train = tr; label = lb; in_valid = 1'b1;
    @(posedge clk);
    while (!done && cnt < 60) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) done = 1;
      else begin
        ena = (cnt >= stall_at && cnt < stall_at + stall_len) ? 1'b0 : 1'b1;
        @(posedge clk);
        cnt++;
      end
    end
    ena = 1'b1;
    checkOutput({tag, "_latency"}, cnt, N_IN + 1 + stall_len);
    checkOutput({tag, "_score"}, int'(out_score), exp_score);
    checkOutput({tag, "_class"}, int'(out_class), exp_class);
    checkOutput({tag, "_mispredict"}, int'(mispredict), exp_mis);
    @(negedge clk);
    checkOutput({tag, "_pulse"}, int'(out_valid || mispredict), 0);
    if (exp_mis != 0) model_learn(f, lb);
  endtask

  // Holds in_valid for 30 cycles and checks accept spacing and every result.
  task automatic handshakeRun(input logic [N_IN-1:0] f, input bit do_write,
                              input int wr_addr, input int wr_val, input string tag);
    int q[$];
    int last_acc = -1;
    int n_acc = 0;
    bit wrote = 0;
    bit write_pending = 0;
    int n = 0;
    wait_idle();
    features = f; train = 1'b0; label = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      w_load = 1'b0;
      if (out_valid) begin
        if (q.size() == 0) checkOutput({tag, "_unexpected_valid"}, 1, 0);
        else checkOutput({tag, "_score"}, int'(out_score), q.pop_front());
      end
      if (do_write && !wrote && n_acc == 1 && out_valid) begin
        w_load = 1'b1;
        w_addr = wr_addr[AW-1:0];
        w_data = wr_val[W_WIDTH-1:0];
        model_write(wr_addr, wr_val);
        wrote = 1;
        write_pending = 1;
      end
      #1;
      if (w_load) checkOutput({tag, "_ready_low"}, int'(in_ready), 0);
      if (in_valid && in_ready) begin
        if (last_acc >= 0) checkOutput({tag, "_gap"}, c - last_acc, write_pending ? 10 : 9);
        write_pending = 0;
        last_acc = c;
        n_acc++;
        q.push_back(model_score(f));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    w_load = 1'b0;
    while (q.size() > 0 && n < 20) begin
      if (out_valid) checkOutput({tag, "_score"}, int'(out_score), q.pop_front());
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_drain"}, q.size(), 0);
    if (do_write) checkOutput({tag, "_wrote"}, int'(wrote), 1);
  endtask

  initial begin
    int seen;
    int w7 [N_IN] = '{3, -2, 5, 0, -1, 4, -6};

    reset_dut();
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_class", int'(out_class), 0);
    checkOutput("rst_out_score", int'(out_score), 0);
    checkOutput("rst_mispredict", int'(mispredict), 0);
    checkOutput("rst_in_ready", int'(in_ready), 1);
    applyStimulus(7'b0000000, 1'b0, 1'b0, -1, 0, "zero_infer");
    checkOutput("zero_infer_spec_score", int'(out_score), 0);

    for (int i = 0; i < N_IN; i++) load_weight(i, w7[i]);
    load_weight(N_IN, -4);
    applyStimulus(7'b0000101, 1'b0, 1'b0, -1, 0, "load_a");
    checkOutput("load_a_spec_score", int'(out_score), 4);
    applyStimulus(7'b1000010, 1'b0, 1'b0, -1, 0, "load_b");
    checkOutput("load_b_spec_score", int'(out_score), -12);

    applyStimulus(7'b0000101, 1'b0, 1'b0, 2, 3, "stall");

    wait_idle();
    features = 7'b1111111; train = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < N_IN; i++) model_w[i] = 0;
    model_bias = 0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput("abort_no_valid", seen, 0);
    applyStimulus(7'b1111111, 1'b0, 1'b0, -1, 0, "abort_reinfer");
    checkOutput("abort_reinfer_spec_score", int'(out_score), 0);

    reset_dut();
    applyStimulus(7'b0000011, 1'b1, 1'b0, -1, 0, "train");
    applyStimulus(7'b0000011, 1'b0, 1'b0, -1, 0, "train_reinfer");
    checkOutput("train_reinfer_spec_score", int'(out_score), -3);
    applyStimulus(7'b1111100, 1'b0, 1'b0, -1, 0, "train_others");
    checkOutput("train_others_spec_score", int'(out_score), -1);

    reset_dut();
    load_weight(0, 31);
    load_weight(1, -32);
    load_weight(N_IN, -32);
    applyStimulus(7'b0000011, 1'b1, 1'b1, -1, 0, "sat");
    checkOutput("sat_spec_score", int'(out_score), -33);
    applyStimulus(7'b0000001, 1'b0, 1'b0, -1, 0, "sat_w0");
    checkOutput("sat_w0_spec_score", int'(out_score), 0);
    applyStimulus(7'b0000010, 1'b0, 1'b0, -1, 0, "sat_w1");
    checkOutput("sat_w1_spec_score", int'(out_score), -62);

    reset_dut();
    for (int i = 0; i < N_IN; i++) load_weight(i, w7[i]);
    load_weight(N_IN, -4);
    handshakeRun(7'b0100101, 1'b0, 0, 0, "hs_plain");
    handshakeRun(7'b0100101, 1'b1, 2, -7, "hs_write");

    for (int k = 0; k < 40; k++) begin
      int len;
      wait_idle();
      if ($urandom_range(2, 0) == 0)
        load_weight(int'($urandom_range(N_IN, 0)), int'($urandom_range(63, 0)) - 32);
      len = ($urandom_range(3, 0) == 0) ? int'($urandom_range(2, 1)) : 0;
      applyStimulus(N_IN'($urandom), 1'($urandom), 1'($urandom),
                    int'($urandom_range(6, 0)), len, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
